fetch_unit: RTL and testbench

Instruction fetch stage feeding the decoder. Holds the program counter, drives the word address of the 64×32 instruction ROM (the ROM samples its address on the falling edge and presents the word before the next rising edge), and captures each returned word with its PC into a 2-entry queue. Decode pulls instructions through a valid/ready handshake. Execute can redirect fetch (branch, `BX`, `BL`) with a single-cycle pulse.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/fetch_queue.sv | 87 ++++++++
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths and types for the fetch stage.
//   ROM_AW / INSTR_W / PC_W : instruction ROM word-address width, instruction width, PC width
//   fetch_state_t           : fetch FSM state encoding
//   fetch_entry_t           : one queued fetch result (byte PC + instruction word)
//   word_align()            : clears the byte-offset bits of an address
package cpu_pkg;

    localparam int ROM_AW  = 6;
    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    typedef enum logic [1:0] {
        PRIME = 2'd0,
        RUN   = 2'd1,
        IDLE  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return addr & ~PC_W'(3);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: two-entry FIFO holding fetched (pc, instr) pairs for decode.
//   clk, rst  : clock, asynchronous active-high reset
//   flush     : synchronous clear; wins over push and pop in the same cycle
//   push      : write wdata at the tail (ignored when full without a pop)
//   pop       : advance the head (ignored when empty)
//   wdata     : entry to write
//   head      : entry at the head, held while no pop occurs
//   count     : number of valid entries
//   full      : both entries valid
//   empty     : no valid entry
module fetch_queue
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  fetch_entry_t  wdata,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    fetch_entry_t ent0_q;
    fetch_entry_t ent1_q;
    logic         vld0_q;
    logic         vld1_q;
    logic         do_pop;

    assign do_pop = pop && vld0_q;

    // Entry 0 is always the head; entry 1 shifts down on a pop so the head
    // register only changes when decode consumes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0_q <= '0;
            ent1_q <= '0;
            vld0_q <= 1'b0;
            vld1_q <= 1'b0;
        end else if (flush) begin
            vld0_q <= 1'b0;
            vld1_q <= 1'b0;
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    if (!vld0_q) begin
                        ent0_q <= wdata;
                        vld0_q <= 1'b1;
                    end else if (!vld1_q) begin
                        ent1_q <= wdata;
                        vld1_q <= 1'b1;
                    end
                end
                2'b01: begin
                    // Keep the old head data when nothing shifts in, so the
                    // outputs never show the unused second slot.
                    if (vld1_q) begin
                        ent0_q <= ent1_q;
                    end
                    vld0_q <= vld1_q;
                    vld1_q <= 1'b0;
                end
                2'b11: begin
                    if (vld1_q) begin
                        ent0_q <= ent1_q;
                        ent1_q <= wdata;
                    end else begin
                        ent0_q <= wdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign head  = ent0_q;
    assign count = CW'(vld0_q) + CW'(vld1_q);
    assign full  = vld1_q;
    assign empty = !vld0_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, addresses the 64x32
// instruction ROM (ROM samples rom_addr on the falling edge of clk) and
// queues returned words with their PC for decode.
//   clk, rst        : clock, asynchronous active-high reset
//   fetch_en        : fetch permitted
//   redirect_valid  : single-cycle redirect from execute
//   redirect_pc     : redirect target byte address (low two bits ignored)
//   rom_addr        : ROM word address, pc_q[7:2] straight from the register
//   rom_data        : ROM output word for the address sampled last falling edge
//   out_valid/ready : decode handshake on the queue head
//   out_instr       : instruction at the queue head
//   out_pc          : byte address of out_instr
//
// state | meaning
// PRIME | ROM output not trusted yet; discard one cycle, then RUN or IDLE
// RUN   | capture rom_data into the queue whenever there is room
// IDLE  | fetch disabled; PC held, returns through PRIME
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int              QDEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [ROM_AW-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc
);

    localparam logic [PC_W-1:0] RESET_PC_ALIGNED = word_align(RESET_PC);
    localparam int              QCW              = $clog2(QDEPTH + 1);

    fetch_state_t    state_q;
    logic [PC_W-1:0] pc_q;

    logic            push;
    logic            pop;
    logic            q_full;
    logic            q_empty;
    logic [QCW-1:0]  q_count;
    fetch_entry_t    q_head;
    fetch_entry_t    q_wdata;
    logic            unused_q_count;

    assign pop       = out_valid && out_ready;
    // A redirect discards whatever the ROM returned this cycle.
    assign push      = (state_q == RUN) && !redirect_valid && (!q_full || pop);
    assign q_wdata   = '{pc: pc_q, instr: rom_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PRIME;
            pc_q    <= RESET_PC_ALIGNED;
        end else if (redirect_valid) begin
            // The ROM reads the target on the coming falling edge, so RUN can
            // capture it directly without another discard cycle.
            pc_q    <= word_align(redirect_pc);
            state_q <= fetch_en ? RUN : IDLE;
        end else begin
            if (push) begin
                pc_q <= pc_q + PC_W'(4);
            end
            case (state_q)
                PRIME:   state_q <= fetch_en ? RUN : IDLE;
                RUN:     if (!fetch_en) state_q <= IDLE;
                IDLE:    if (fetch_en) state_q <= PRIME;
                default: state_q <= PRIME;
            endcase
        end
    end

    // Word address aliases every 256 bytes by design.
    assign rom_addr = pc_q[ROM_AW+1:2];

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .wdata (q_wdata),
        .head  (q_head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    assign unused_q_count = ^q_count;

    assign out_valid = !q_empty;
    assign out_instr = q_head.instr;
    assign out_pc    = q_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: cycle table for fetch_unit plus an in-order scoreboard of
// every instruction handed to decode.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] E0 = 32'he3a00004;
    localparam logic [31:0] E1 = 32'he3a01001;
    localparam logic [31:0] E2 = 32'he3a02002;
    localparam logic [31:0] E3 = 32'he3a0300a;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [5:0]  rom_addr;
    logic [31:0] rom_data = '0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    logic [31:0] rom [64];

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_pops = 0;

    fetch_entry_t sb[$];
    logic [31:0]  gen_pc;

    typedef struct packed {
        logic        rst;
        logic        fe;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [5:0]  eaddr;
    } vec_t;

    vec_t vt[$];

    fetch_unit #(
        .RESET_PC (RST_PC),
        .QDEPTH   (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    // ROM model: samples the address on the falling edge.
    always @(negedge clk) rom_data <= rom[rom_addr];

    function automatic logic [31:0] rom_word(input int i);
        case (i)
            0:       return E0;
            1:       return E1;
            2:       return E2;
            3:       return E3;
            default: return 32'hC0DE_0000 | 32'(i);
        endcase
    endfunction

    function automatic vec_t v(input logic r, input logic f, input logic rd, input logic rv,
                               input logic [31:0] rpc, input logic ev, input logic [31:0] epc,
                               input logic [31:0] ei, input logic [5:0] ea);
        return '{r, f, rd, rv, rpc, ev, epc, ei, ea};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic sb_extend();
        sb.push_back('{pc: gen_pc, instr: rom_word(int'(gen_pc[7:2]))});
        gen_pc = gen_pc + 32'd4;
    endtask

    task automatic sb_restart(input logic [31:0] pc);
        sb.delete();
        gen_pc = pc & ~32'h3;
        for (int i = 0; i < 4; i++) sb_extend();
    endtask

    // Every handshake must deliver the next address of the current stream.
    always @(negedge clk) begin
        fetch_entry_t e;
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) sb_extend();
                e = sb.pop_front();
                n_pops++;
                check("pop_pc", out_pc, e.pc);
                check("pop_instr", out_instr, e.instr);
            end
            if (redirect_valid) sb_restart(redirect_pc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_cmp %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = rom_word(i);

        //          rst fe rdy rv rpc           ev epc           einstr        eaddr
        // startup stream
        vt.push_back(v(1, 1, 1, 0, 32'h0,       0, 32'h0,       32'h0,        6'd0));
        vt.push_back(v(0, 1, 1, 0, 32'h0,       0, 32'h0,       32'h0,        6'd0));
        vt.push_back(v(0, 1, 1, 0, 32'h0,       1, 32'h0,       E0,           6'd1));
        vt.push_back(v(0, 1, 1, 0, 32'h0,       1, 32'h4,       E1,           6'd2));
        vt.push_back(v(0, 1, 1, 0, 32'h0,       1, 32'h8,       E2,           6'd3));
        vt.push_back(v(0, 1, 1, 0, 32'h0,       1, 32'hC,       E3,           6'd4));
        // backpressure: queue fills, address freezes
        vt.push_back(v(1, 1, 1, 0, 32'h0,       0, 32'h0,       32'h0,        6'd0));
        vt.push_back(v(0, 1, 1, 0, 32'h0,       0, 32'h0,       32'h0,        6'd0));
        vt.push_back(v(0, 1, 0, 0, 32'h0,       1, 32'h0,       E0,           6'd1));
        vt.push_back(v(0, 1, 0, 0, 32'h0,       1, 32'h0,       E0,           6'd2));
        vt.push_back(v(0, 1, 0, 0, 32'h0,       1, 32'h0,       E0,           6'd2));
        vt.push_back(v(0, 1, 0, 0, 32'h0,       1, 32'h0,       E0,           6'd2));
        vt.push_back(v(0, 1, 0, 0, 32'h0,       1, 32'h0,       E0,           6'd2));
        vt.push_back(v(0, 1, 1, 0, 32'h0,       1, 32'h4,       E1,           6'd3));
        vt.push_back(v(0, 1, 1, 0, 32'h0,       1, 32'h8,       E2,           6'd4));
        // redirect to 0x33 while full, then to 0xFC with a same-cycle pop
        vt.push_back(v(0, 1, 0, 0, 32'h0,       1, 32'h8,       E2,           6'd4));
        vt.push_back(v(0, 1, 0, 1, 32'h33,      0, 32'h0,       32'h0,        6'd12));
        vt.push_back(v(0, 1, 0, 0, 32'h0,       1, 32'h30,      rom_word(12), 6'd13));
        vt.push_back(v(0, 1, 1, 1, 32'hFC,      0, 32'h0,       32'h0,        6'd63));
        vt.push_back(v(0, 1, 1, 0, 32'h0,       1, 32'hFC,      rom_word(63), 6'd0));
        vt.push_back(v(0, 1, 1, 0, 32'h0,       1, 32'h100,     E0,           6'd1));
        // fetch_en low for three cycles, then resume through PRIME
        vt.push_back(v(0, 0, 1, 0, 32'h0,       1, 32'h104,     E1,           6'd2));
        vt.push_back(v(0, 0, 1, 0, 32'h0,       0, 32'h0,       32'h0,        6'd2));
        vt.push_back(v(0, 0, 1, 0, 32'h0,       0, 32'h0,       32'h0,        6'd2));
        vt.push_back(v(0, 1, 1, 0, 32'h0,       0, 32'h0,       32'h0,        6'd2));
        vt.push_back(v(0, 1, 1, 0, 32'h0,       0, 32'h0,       32'h0,        6'd2));
        vt.push_back(v(0, 1, 1, 0, 32'h0,       1, 32'h108,     E2,           6'd3));
        vt.push_back(v(0, 1, 1, 0, 32'h0,       1, 32'h10C,     E3,           6'd4));
        // refill to full ahead of the asynchronous reset
        vt.push_back(v(0, 1, 0, 0, 32'h0,       1, 32'h10C,     E3,           6'd5));
        vt.push_back(v(0, 1, 0, 0, 32'h0,       1, 32'h10C,     E3,           6'd5));

        rst            = 1'b1;
        fetch_en       = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        sb_restart(RST_PC);
        #1;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_addr", 32'(rom_addr), 32'd0);

        for (int i = 0; i < vt.size(); i++) begin
            rst            = vt[i].rst;
            fetch_en       = vt[i].fe;
            out_ready      = vt[i].rdy;
            redirect_valid = vt[i].rv;
            redirect_pc    = vt[i].rpc;
            if (vt[i].rst) sb_restart(RST_PC);
            @(posedge clk);
            #1;
            check($sformatf("row%0d_valid", i), 32'(out_valid), 32'(vt[i].ev));
            check($sformatf("row%0d_addr", i), 32'(rom_addr), 32'(vt[i].eaddr));
            if (vt[i].ev || vt[i].rst) begin
                check($sformatf("row%0d_pc", i), out_pc, vt[i].epc);
                check($sformatf("row%0d_instr", i), out_instr, vt[i].einstr);
            end
        end

        // Asynchronous reset on a falling edge with the queue full.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_pc", out_pc, 32'd0);
        check("arst_instr", out_instr, 32'd0);
        check("arst_addr", 32'(rom_addr), 32'd0);
        sb_restart(RST_PC);

        @(posedge clk);
        #1;
        rst       = 1'b0;
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        check("arst_hold_valid", 32'(out_valid), 32'd0);

        @(posedge clk);
        #1;
        check("arst_prime_valid", 32'(out_valid), 32'd0);
        check("arst_prime_addr", 32'(rom_addr), 32'd0);

        @(posedge clk);
        #1;
        check("arst_first_valid", 32'(out_valid), 32'd1);
        check("arst_first_pc", out_pc, RST_PC);
        check("arst_first_instr", out_instr, E0);
        check("arst_first_addr", 32'(rom_addr), 32'd1);

        @(posedge clk);
        #1;
        check("arst_second_pc", out_pc, 32'h4);
        check("arst_second_instr", out_instr, E1);

        check("total_pops", 32'(n_pops), 32'd11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
